// File: rtl/serdes_pkg.sv
// serdes_pkg: definitions shared by the SERDES transmit and receive sides.
//   rx_state_e        : receive alignment state (hunting for sync / locked)
//   SYNC_BYTE_DEFAULT : default alignment / frame-delimiter byte
//   byte_is_sync()    : sync byte comparison used by the deframer
package serdes_pkg;

  typedef enum logic {
    RX_HUNT   = 1'b0,
    RX_LOCKED = 1'b1
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hBC;

  function automatic logic byte_is_sync(input logic [7:0] b, input logic [7:0] sync);
    return (b == sync);
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: small byte FIFO, pointer-plus-count implementation.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push_i     : write data_i this cycle (ignored when full unless pop_i)
//   data_i     : byte to write
//   pop_i      : remove head this cycle (ignored when empty)
//   full_o     : FIFO holds DEPTH entries
//   empty_o    : FIFO holds no entries
//   head_o     : oldest entry (storage is zeroed on reset, so 8'h00 when empty after reset)
module sync_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en_s;
  logic          rd_en_s;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly where
  // wr_ptr points, so the write may proceed in the same cycle.
  assign wr_en_s = push_i & (~full_o | pop_i);
  assign rd_en_s = pop_i & ~empty_o;

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/serdes_rx_deframer.sv
// serdes_rx_deframer: serial-to-byte receive deframer.
// Hunts for SYNC_BYTE in the MSB-first bitstream, then deframes FRAME_LEN data
// bytes between sync slots into a byte FIFO with a valid/ready interface.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, clears all state
//   ser_in     : serial data bit
//   ser_en     : ser_in is valid this cycle
//   dout       : FIFO head byte
//   dout_valid : FIFO non-empty
//   dout_ready : consumer accepts dout
//   locked     : alignment established
//   sync_err   : one-cycle pulse per bad sync slot
//   overflow   : sticky, a data byte was dropped on a full FIFO
module serdes_rx_deframer
  import serdes_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         FRAME_LEN  = 4,
  parameter int         MISS_MAX   = 2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_in,
  input  logic       ser_en,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       locked,
  output logic       sync_err,
  output logic       overflow
);

  localparam logic [3:0] FRAME_LEN_C = 4'(FRAME_LEN);
  localparam logic [2:0] MISS_MAX_C  = 3'(MISS_MAX);

  rx_state_e  state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       sync_err_q, sync_err_d;
  logic       overflow_q, overflow_d;

  logic [7:0] sr_next_s;
  logic [2:0] miss_inc_s;
  logic       push_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;
  logic [7:0] head_s;

  assign sr_next_s  = {sr_q[6:0], ser_in};
  assign miss_inc_s = miss_cnt_q + 3'd1;
  assign pop_s      = ~empty_s & dout_ready;

  // Next-state logic: alignment FSM, shift register, counters, push request
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    miss_cnt_d = miss_cnt_q;
    sync_err_d = 1'b0;
    push_s     = 1'b0;
    if (ser_en) begin
      sr_d = sr_next_s;
      case (state_q)
        RX_HUNT: begin
          // Bit-by-bit search; a match defines the byte boundary.
          if (byte_is_sync(sr_next_s, SYNC_BYTE)) begin
            state_d    = RX_LOCKED;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            miss_cnt_d = 3'd0;
          end else begin
            state_d = RX_HUNT;
          end
        end
        RX_LOCKED: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (byte_cnt_q < FRAME_LEN_C) begin
              push_s     = 1'b1;
              byte_cnt_d = byte_cnt_q + 4'd1;
            end else begin
              // Sync slot: never pushed, only checked.
              byte_cnt_d = 4'd0;
              if (byte_is_sync(sr_next_s, SYNC_BYTE)) begin
                miss_cnt_d = 3'd0;
              end else begin
                sync_err_d = 1'b1;
                if (miss_inc_s == MISS_MAX_C) begin
                  // Lock lost; sr is kept so the hunt continues seamlessly.
                  state_d    = RX_HUNT;
                  miss_cnt_d = 3'd0;
                end else begin
                  miss_cnt_d = miss_inc_s;
                end
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = RX_HUNT;
        end
      endcase
    end else begin
      sr_d = sr_q;
    end
  end

  // Sticky overflow: a push that the FIFO cannot accept this cycle
  always_comb begin
    overflow_d = overflow_q;
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RX_HUNT;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      miss_cnt_q <= 3'd0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  (sr_next_s),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_s)
  );

  assign dout       = head_s;
  assign dout_valid = ~empty_s;
  assign locked     = (state_q == RX_LOCKED);
  assign sync_err   = sync_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// Directed testbench for serdes_rx_deframer.
module tb_serdes_rx_deframer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in;
  logic       ser_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       locked;
  logic       sync_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int serr_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp[$];

  always #5 clk = ~clk;

  serdes_rx_deframer dut (
    .clk        (clk),
    .reset      (reset),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .sync_err   (sync_err),
    .overflow   (overflow)
  );

  // Record every byte the consumer accepts and every sync_err pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (dout_valid && dout_ready) got.push_back(dout);
      if (sync_err) serr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Send bits v[hi]..v[lo] MSB first; optional random idle gap after each bit.
  task automatic send_bits(input logic [7:0] v, input int hi, input int lo, input int gap_max);
    for (int i = hi; i >= lo; i--) begin
      ser_in = v[i];
      ser_en = 1'b1;
      @(posedge clk);
      #1;
      ser_en = 1'b0;
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 1)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap_max);
    send_bits(v, 7, 0, gap_max);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input int gap_max);
    send_byte(a, gap_max);
    send_byte(b, gap_max);
    send_byte(c, gap_max);
    send_byte(d, gap_max);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    got.delete();
    exp.delete();
    serr_cnt = 0;
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, {24'h0, got[i]}, {24'h0, exp[i]});
      else chk(tag, 32'hFFFF_FFFF, {24'h0, exp[i]});
    end
    got.delete();
    exp.delete();
  endtask

  initial begin
    reset      = 1'b1;
    ser_in     = 1'b0;
    ser_en     = 1'b0;
    dout_ready = 1'b1;
    #1;
    chk("rst_dout", {24'h0, dout}, 32'h00);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_sync_err", {31'h0, sync_err}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    @(posedge clk);
    #1;

    // Test 1: clean stream
    do_reset();
    send_bits(8'hBC, 7, 1, 0);
    chk("t1_prelock", {31'h0, locked}, 32'h0);
    send_bits(8'hBC, 0, 0, 0);
    chk("t1_lock", {31'h0, locked}, 32'h1);
    send_byte(8'h27, 0);
    chk("t1_lat_valid", {31'h0, dout_valid}, 32'h1);
    chk("t1_lat_dout", {24'h0, dout}, 32'h27);
    send_byte(8'h3C, 0);
    send_byte(8'h5F, 0);
    send_byte(8'h99, 0);
    send_byte(8'hBC, 0);
    wait_cycles(3);
    exp = '{8'h27, 8'h3C, 8'h5F, 8'h99};
    check_q("t1_data");
    chk("t1_serr", serr_cnt, 32'd0);
    chk("t1_locked_end", {31'h0, locked}, 32'h1);

    // Test 2: three junk bits ahead of the sync byte
    do_reset();
    send_bits(8'hA0, 7, 5, 0);
    send_bits(8'hBC, 7, 1, 0);
    chk("t2_prelock", {31'h0, locked}, 32'h0);
    send_bits(8'hBC, 0, 0, 0);
    chk("t2_lock", {31'h0, locked}, 32'h1);
    send_frame(8'h27, 8'h3C, 8'h5F, 8'h99, 0);
    send_byte(8'hBC, 0);
    wait_cycles(3);
    exp = '{8'h27, 8'h3C, 8'h5F, 8'h99};
    check_q("t2_data");

    // Test 3: consumer stalled, second frame overflows
    do_reset();
    dout_ready = 1'b0;
    send_byte(8'hBC, 0);
    send_frame(8'h27, 8'h3C, 8'h5F, 8'h99, 0);
    send_byte(8'hBC, 0);
    chk("t3_ovf_before", {31'h0, overflow}, 32'h0);
    chk("t3_head", {24'h0, dout}, 32'h27);
    send_frame(8'hAA, 8'hFF, 8'h01, 8'hC3, 0);
    chk("t3_ovf_after", {31'h0, overflow}, 32'h1);
    chk("t3_head_stable", {24'h0, dout}, 32'h27);
    chk("t3_valid_stall", {31'h0, dout_valid}, 32'h1);
    dout_ready = 1'b1;
    wait_cycles(8);
    exp = '{8'h27, 8'h3C, 8'h5F, 8'h99};
    check_q("t3_data");
    chk("t3_empty", {31'h0, dout_valid}, 32'h0);
    chk("t3_ovf_sticky", {31'h0, overflow}, 32'h1);

    // Test 4: single bad sync slot, then two consecutive bad slots
    do_reset();
    send_byte(8'hBC, 0);
    send_frame(8'h27, 8'h3C, 8'h5F, 8'h99, 0);
    send_byte(8'hBD, 0);
    chk("t4_serr_pulse", {31'h0, sync_err}, 32'h1);
    chk("t4_still_locked", {31'h0, locked}, 32'h1);
    wait_cycles(1);
    chk("t4_serr_one_cycle", {31'h0, sync_err}, 32'h0);
    send_frame(8'hAA, 8'hFF, 8'h01, 8'hC3, 0);
    send_byte(8'hBC, 0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    send_byte(8'hBD, 0);
    chk("t4_locked_miss1", {31'h0, locked}, 32'h1);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);
    send_byte(8'hBD, 0);
    chk("t4_unlocked", {31'h0, locked}, 32'h0);
    chk("t4_serr_miss2", {31'h0, sync_err}, 32'h1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    chk("t4_no_push_hunt", {31'h0, dout_valid}, 32'h0);
    chk("t4_still_hunt", {31'h0, locked}, 32'h0);
    send_byte(8'hBC, 0);
    chk("t4_relock", {31'h0, locked}, 32'h1);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 0);
    wait_cycles(3);
    exp = '{8'h27, 8'h3C, 8'h5F, 8'h99, 8'hAA, 8'hFF, 8'h01, 8'hC3,
            8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
            8'h12, 8'h34, 8'h56, 8'h78};
    check_q("t4_data");
    chk("t4_serr_total", serr_cnt, 32'd3);

    // Test 5: random ser_en gaps between bits
    do_reset();
    send_byte(8'hBC, 5);
    send_frame(8'h27, 8'h3C, 8'h5F, 8'h99, 5);
    send_byte(8'hBC, 5);
    wait_cycles(3);
    exp = '{8'h27, 8'h3C, 8'h5F, 8'h99};
    check_q("t5_data");
    chk("t5_serr", serr_cnt, 32'd0);
    chk("t5_locked", {31'h0, locked}, 32'h1);

    // Test 6: asynchronous reset mid-byte with two bytes queued
    do_reset();
    dout_ready = 1'b0;
    send_byte(8'hBC, 0);
    send_byte(8'h27, 0);
    send_byte(8'h3C, 0);
    send_bits(8'h5A, 7, 5, 0);
    chk("t6_pre_valid", {31'h0, dout_valid}, 32'h1);
    chk("t6_pre_locked", {31'h0, locked}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("t6_rst_locked", {31'h0, locked}, 32'h0);
    chk("t6_rst_dout", {24'h0, dout}, 32'h00);
    #2;
    reset = 1'b0;
    got.delete();
    wait_cycles(1);
    dout_ready = 1'b1;
    wait_cycles(3);
    chk("t6_empty_after", {31'h0, dout_valid}, 32'h0);
    chk("t6_unlocked_after", {31'h0, locked}, 32'h0);
    send_byte(8'hBC, 0);
    chk("t6_relock", {31'h0, locked}, 32'h1);
    send_byte(8'h5A, 0);
    wait_cycles(3);
    exp = '{8'h5A};
    check_q("t6_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
